// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the Pmod DAC: one free-running divider derives mclk/sck/lrck, serialises captured L/R samples.
// Latency: samples captured at frame wrap; first MSB on sdin 2^SCK_LOG2 clk after the wrap.
// Backpressure: none; free-running, inputs are sampled once per frame and otherwise ignored.
module audio_i2s_tx #(
  parameter int CNT_W     = 9,
  parameter int SCK_LOG2  = 3,
  parameter int MCLK_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  // Number of bits in the slot index within one channel half.
  localparam int SLOT_W = CNT_W - 1 - SCK_LOG2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       hold_l_q, hold_l_d;
  logic [15:0]       hold_r_q, hold_r_d;
  logic              sdin_q, sdin_d;
  logic              tick_q, tick_d;

  logic [CNT_W-1:0]  cnt_nxt;
  logic              wrap;
  logic              bit_edge;
  logic [SLOT_W-1:0] slot_nxt;
  logic              ch_nxt;
  logic [15:0]       word_nxt;
  logic              slot_bit;

  // Divider counter and once-per-frame capture of both channels on the wrap edge.
  always_comb begin
    cnt_nxt  = cnt_q + CNT_W'(1);
    wrap     = &cnt_q;
    cnt_d    = cnt_nxt;
    hold_l_d = wrap ? audio_left  : hold_l_q;
    hold_r_d = wrap ? audio_right : hold_r_q;
    tick_d   = wrap;
  end

  // Serial bit for the slot that begins after this edge; only loaded when sck is about to fall.
  // Slot 0 is the I2S one-bit delay, slots 1..16 carry MSB..LSB, the rest are zero pad.
  // The slot-0 bit is loaded on the wrap edge itself, so the stale hold value is never used.
  always_comb begin
    slot_nxt = cnt_nxt[CNT_W-2:SCK_LOG2];
    ch_nxt   = cnt_nxt[CNT_W-1];
    word_nxt = ch_nxt ? hold_r_q : hold_l_q;
    slot_bit = 1'b0;
    if ((slot_nxt >= SLOT_W'(1)) && (slot_nxt <= SLOT_W'(16))) begin
      slot_bit = word_nxt[4'(16 - 32'(slot_nxt))];
    end
    bit_edge = &cnt_q[SCK_LOG2-1:0];
    sdin_d   = bit_edge ? slot_bit : sdin_q;
  end

  // State registers; everything clears asynchronously so a mid-frame reset aborts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sdin_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sdin_q   <= sdin_d;
      tick_q   <= tick_d;
    end
  end

  // Clocks are raw counter bits so they never glitch.
  assign audio_mclk  = cnt_q[MCLK_LOG2-1];
  assign audio_sck   = cnt_q[SCK_LOG2-1];
  assign audio_lrck  = cnt_q[CNT_W-1];
  assign audio_sdin  = sdin_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx with default parameters (512-cycle frame, 8-cycle sck).
// Frames are decoded by sampling sdin on sck rising edges and compared against slot patterns.
// Clock outputs and sdin stability are checked every cycle of every decoded frame.
module tb_audio_i2s_tx;

  logic        clk;
  logic        rst;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_tick;

  int checks;
  int failures;

  audio_i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 32-slot pattern of one channel half, slot 0 in bit 31.
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_l_pat;
    logic [31:0] exp_r_pat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Waits (bounded) at negedges until sample_tick is seen; returns at the negedge where cnt==0.
  task automatic wait_tick(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check(name, 32'(found), 32'd1);
  endtask

  // Decodes one frame starting at the negedge where cnt==0. Optional mid-frame input changes at cycle offsets.
  task automatic capture_frame(input string name,
                               input int chg_r_at, input logic [15:0] new_r,
                               input int chg_l_at, input logic [15:0] new_l,
                               output logic [31:0] pl, output logic [31:0] pr);
    int   clk_errs;
    int   stab_errs;
    logic prev;
    logic [8:0] c9;
    clk_errs  = 0;
    stab_errs = 0;
    pl = '0;
    pr = '0;
    prev = audio_sdin;
    for (int c = 0; c < 512; c++) begin
      c9 = 9'(c);
      if (c == chg_r_at) audio_right = new_r;
      if (c == chg_l_at) audio_left  = new_l;
      if (audio_mclk !== c9[1] || audio_sck !== c9[2] || audio_lrck !== c9[8] ||
          sample_tick !== (c == 0)) clk_errs++;
      if (c9[2:0] != 3'd0 && audio_sdin !== prev) stab_errs++;
      if (c9[2:0] == 3'd4) begin
        if (c9[8]) pr[31 - int'(c9[7:3])] = audio_sdin;
        else       pl[31 - int'(c9[7:3])] = audio_sdin;
      end
      prev = audio_sdin;
      @(negedge clk);
    end
    check({name, "_clk_align"}, 32'(clk_errs), 32'd0);
    check({name, "_sdin_stable"}, 32'(stab_errs), 32'd0);
  endtask

  // Releases reset at a negedge and checks the first frame is silent and the first tick lands 512 clk later.
  task automatic release_and_count(input string name);
    int cycles;
    int ones;
    logic found;
    cycles = 0;
    ones   = 0;
    found  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      cycles++;
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
      if (audio_sdin) ones++;
    end
    check({name, "_tick_seen"}, 32'(found), 32'd1);
    check({name, "_first_tick_cycles"}, 32'(cycles), 32'd512);
    check({name, "_first_frame_silent"}, 32'(ones), 32'd0);
  endtask

  vec_t        vecs[4];
  logic [31:0] pl, pr, dl, dr;
  logic [15:0] rl, rr, pend_l, pend_r;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    audio_left  = 16'h8001;
    audio_right = 16'h7FFE;

    vecs[0] = '{l: 16'h8001, r: 16'h7FFE, exp_l_pat: 32'h4000_8000, exp_r_pat: 32'h3FFF_0000};
    vecs[1] = '{l: 16'hFB00, r: 16'h0500, exp_l_pat: 32'h7D80_0000, exp_r_pat: 32'h0280_0000};
    vecs[2] = '{l: 16'h0000, r: 16'hFFFF, exp_l_pat: 32'h0000_0000, exp_r_pat: 32'h7FFF_8000};
    vecs[3] = '{l: 16'h1234, r: 16'h8000, exp_l_pat: 32'h091A_0000, exp_r_pat: 32'h4000_0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}), 32'd0);

    // Release: first frame carries zero holds even though inputs are non-zero.
    @(negedge clk);
    release_and_count("por");

    // Table-driven frames: apply inputs, let them be captured at the next wrap, decode that frame.
    for (int i = 0; i < 4; i++) begin
      audio_left  = vecs[i].l;
      audio_right = vecs[i].r;
      capture_frame($sformatf("v%0d_pre", i), -1, 16'h0, -1, 16'h0, dl, dr);
      capture_frame($sformatf("v%0d", i), -1, 16'h0, -1, 16'h0, pl, pr);
      check($sformatf("v%0d_left", i), pl, vecs[i].exp_l_pat);
      check($sformatf("v%0d_right", i), pr, vecs[i].exp_r_pat);
    end

    // Mid-frame input changes: right changes in left slot 4, left changes in right slot 8.
    audio_left  = 16'h1234;
    audio_right = 16'h5678;
    capture_frame("mid_pre", -1, 16'h0, -1, 16'h0, dl, dr);
    capture_frame("mid_cur", 32, 16'hBEEF, 256 + 64, 16'hAAAA, pl, pr);
    check("mid_cur_left", pl, 32'h091A_0000);
    check("mid_cur_right", pr, 32'h2B3C_0000);
    capture_frame("mid_next", -1, 16'h0, -1, 16'h0, pl, pr);
    check("mid_next_left", pl, 32'h5555_0000);
    check("mid_next_right", pr, 32'h5F77_8000);

    // Random samples: each frame's inputs are captured at its end and decoded in the following frame.
    pend_l = '0;
    pend_r = '0;
    for (int i = 0; i <= 10; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      audio_left  = rl;
      audio_right = rr;
      capture_frame($sformatf("rnd%0d", i), -1, 16'h0, -1, 16'h0, pl, pr);
      if (i > 0) begin
        check($sformatf("rnd%0d_left", i), pl, {1'b0, pend_l, 15'b0});
        check($sformatf("rnd%0d_right", i), pr, {1'b0, pend_r, 15'b0});
      end
      pend_l = rl;
      pend_r = rr;
    end

    // Mid-frame asynchronous reset at cnt=300 (right half, lrck high).
    repeat (300) @(negedge clk);
    check("pre_rst_lrck", 32'(audio_lrck), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs",
             32'({audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}), 32'd0);
    repeat (3) @(negedge clk);
    check("held_rst_outputs",
          32'({audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}), 32'd0);
    audio_left  = 16'hFFFF;
    audio_right = 16'hFFFF;
    release_and_count("midrst");
    capture_frame("post_rst", -1, 16'h0, -1, 16'h0, pl, pr);
    check("post_rst_left", pl, 32'h7FFF_8000);
    check("post_rst_right", pr, 32'h7FFF_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
